// File: rtl/risc_v_soc_pkg.sv
// risc_v_soc_pkg -- shared definitions for the RV32I-subset SoC.
// Holds opcode/funct3/funct7 constants, the ALU operation enumeration,
// the NOP encoding, the decoded-control record carried down the pipeline
// and the instruction decoder used in ID.
package risc_v_soc_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // ALU_ADD must stay first: an all-zero control record is a NOP.
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_AND,
        ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA
    } alu_op_e;

    typedef struct packed {
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
        logic        is_branch;
        logic        br_ne;
        logic        use_imm;
        alu_op_e     alu_op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } ctrl_t;

    // Unsupported encodings decode to all-zero control. Writes to x0 are
    // dropped here (reg_we=0, rd=0) so nothing downstream sees them.
    function automatic ctrl_t decode(input logic [31:0] insn);
        ctrl_t      c;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       ok;
        c   = '0;
        ok  = 1'b0;
        opc = insn[6:0];
        f3  = insn[14:12];
        f7  = insn[31:25];
        c.rs1 = insn[19:15];
        c.rs2 = insn[24:20];
        case (opc)
            OPC_OP_IMM: begin
                c.use_imm = 1'b1;
                c.imm     = {{20{insn[31]}}, insn[31:20]};
                c.reg_we  = 1'b1;
                case (f3)
                    F3_ADD:  begin ok = 1'b1; c.alu_op = ALU_ADD; end
                    F3_SLT:  begin ok = 1'b1; c.alu_op = ALU_SLT; end
                    F3_XOR:  begin ok = 1'b1; c.alu_op = ALU_XOR; end
                    F3_OR:   begin ok = 1'b1; c.alu_op = ALU_OR;  end
                    F3_AND:  begin ok = 1'b1; c.alu_op = ALU_AND; end
                    default: ok = 1'b0;
                endcase
            end
            OPC_OP: begin
                c.reg_we = 1'b1;
                if (f7 == F7_BASE) begin
                    ok = 1'b1;
                    case (f3)
                        F3_ADD:  c.alu_op = ALU_ADD;
                        F3_SLL:  c.alu_op = ALU_SLL;
                        F3_SLT:  c.alu_op = ALU_SLT;
                        F3_SLTU: c.alu_op = ALU_SLTU;
                        F3_XOR:  c.alu_op = ALU_XOR;
                        F3_SR:   c.alu_op = ALU_SRL;
                        F3_OR:   c.alu_op = ALU_OR;
                        default: c.alu_op = ALU_AND;
                    endcase
                end else if (f7 == F7_ALT && f3 == F3_ADD) begin
                    ok = 1'b1;
                    c.alu_op = ALU_SUB;
                end else if (f7 == F7_ALT && f3 == F3_SR) begin
                    ok = 1'b1;
                    c.alu_op = ALU_SRA;
                end
            end
            OPC_LOAD: begin
                ok        = (f3 == F3_WORD);
                c.reg_we  = 1'b1;
                c.mem_re  = 1'b1;
                c.use_imm = 1'b1;
                c.imm     = {{20{insn[31]}}, insn[31:20]};
            end
            OPC_STORE: begin
                ok        = (f3 == F3_WORD);
                c.mem_we  = 1'b1;
                c.use_imm = 1'b1;
                c.imm     = {{20{insn[31]}}, insn[31:25], insn[11:7]};
            end
            OPC_BRANCH: begin
                ok          = (f3 == F3_BEQ) || (f3 == F3_BNE);
                c.is_branch = 1'b1;
                c.br_ne     = f3[0];
                c.imm       = {{19{insn[31]}}, insn[31], insn[7],
                               insn[30:25], insn[11:8], 1'b0};
            end
            default: ok = 1'b0;
        endcase
        if (!ok)
            c = '0;
        if (c.reg_we && insn[11:7] != 5'd0) begin
            c.rd = insn[11:7];
        end else begin
            c.reg_we = 1'b0;
            c.rd     = '0;
        end
        return c;
    endfunction

endpackage

// File: rtl/riscv_alu.sv
// riscv_alu -- combinational 32-bit ALU.
// Ports: op (operation), a/b (operands), y (result). Shifts use b[4:0].
import risc_v_soc_pkg::*;

module riscv_alu (
    input  alu_op_e     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_SLT:  y = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: y = {31'd0, a < b};
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_SLL:  y = a << b[4:0];
            ALU_SRL:  y = a >> b[4:0];
            ALU_SRA:  y = $signed(a) >>> b[4:0];
            default:  y = a + b;
        endcase
    end
endmodule

// File: rtl/riscv_core.sv
// riscv_core -- 5-stage in-order RV32I-subset pipeline (IF ID EX MEM WB)
// with register file, data RAM, forwarding and load-use interlock.
// Ports: clk, reset (async, active low), imem_word_addr (PC[31:2] to ROM),
// imem_data (fetched instruction).
import risc_v_soc_pkg::*;

module riscv_core #(
    parameter int unsigned DMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    output logic [29:0] imem_word_addr,
    input  logic [31:0] imem_data
);
    localparam int unsigned DW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

    logic [31:0] pc_now;
    logic        wb_re;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        branch_taken;

    logic [31:0] if_id_insn, if_id_pc;
    ctrl_t       id_ctrl;
    logic [31:0] id_a, id_b;
    logic        id_uses_rs1, id_uses_rs2, load_use;

    ctrl_t       id_ex_ctrl;
    logic [31:0] id_ex_pc, id_ex_a, id_ex_b;
    logic [31:0] ex_a, ex_b, ex_alu_b, ex_y, ex_target;

    logic        ex_mem_reg_we, ex_mem_re, ex_mem_we;
    logic [4:0]  ex_mem_rd;
    logic [31:0] ex_mem_y, ex_mem_store;

    logic [31:0]   dmem [DMEM_WORDS];
    logic [DW-1:0] dmem_idx;
    logic [31:0]   mem_result;

    logic        mem_wb_we;
    logic [4:0]  mem_wb_rd;
    logic [31:0] mem_wb_data;

    logic [31:0] regs [32];

    assign imem_word_addr = pc_now[31:2];
    assign wb_re   = mem_wb_we;
    assign wb_rd   = mem_wb_rd;
    assign wb_data = mem_wb_data;

    // ID: decode, register read with same-cycle WB bypass, load-use check
    always_comb begin
        id_ctrl = decode(if_id_insn);
        if (id_ctrl.rs1 == 5'd0)                    id_a = '0;
        else if (wb_re && wb_rd == id_ctrl.rs1)     id_a = wb_data;
        else                                        id_a = regs[id_ctrl.rs1];
        if (id_ctrl.rs2 == 5'd0)                    id_b = '0;
        else if (wb_re && wb_rd == id_ctrl.rs2)     id_b = wb_data;
        else                                        id_b = regs[id_ctrl.rs2];
        id_uses_rs1 = id_ctrl.reg_we | id_ctrl.mem_we | id_ctrl.is_branch;
        id_uses_rs2 = id_ctrl.mem_we | id_ctrl.is_branch |
                      (id_ctrl.reg_we & ~id_ctrl.use_imm & ~id_ctrl.mem_re);
        load_use = id_ex_ctrl.mem_re & id_ex_ctrl.reg_we &
                   ((id_uses_rs1 & (id_ctrl.rs1 == id_ex_ctrl.rd)) |
                    (id_uses_rs2 & (id_ctrl.rs2 == id_ex_ctrl.rd)));
    end

    // EX operand forwarding: MEM/WB applied first so EX/MEM (younger) overrides.
    // rd is never 0 when a write is enabled, so x0 is never forwarded.
    always_comb begin
        ex_a = id_ex_a;
        ex_b = id_ex_b;
        if (mem_wb_we && mem_wb_rd == id_ex_ctrl.rs1) ex_a = mem_wb_data;
        if (mem_wb_we && mem_wb_rd == id_ex_ctrl.rs2) ex_b = mem_wb_data;
        if (ex_mem_reg_we && !ex_mem_re && ex_mem_rd == id_ex_ctrl.rs1) ex_a = ex_mem_y;
        if (ex_mem_reg_we && !ex_mem_re && ex_mem_rd == id_ex_ctrl.rs2) ex_b = ex_mem_y;
        ex_alu_b     = id_ex_ctrl.use_imm ? id_ex_ctrl.imm : ex_b;
        ex_target    = id_ex_pc + id_ex_ctrl.imm;
        branch_taken = id_ex_ctrl.is_branch & ((ex_a == ex_b) ^ id_ex_ctrl.br_ne);
    end

    riscv_alu alu_1 (
        .op (id_ex_ctrl.alu_op),
        .a  (ex_a),
        .b  (ex_alu_b),
        .y  (ex_y)
    );

    // MEM: word-addressed RAM, combinational read
    always_comb begin
        dmem_idx   = DW'(ex_mem_y[31:2] % 30'(DMEM_WORDS));
        mem_result = ex_mem_re ? dmem[dmem_idx] : ex_mem_y;
    end

    always_ff @(posedge clk) begin
        if (ex_mem_we)
            dmem[dmem_idx] <= ex_mem_store;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 32; i++)
                regs[i] <= '0;
        end else if (wb_re) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Taken branch flushes IF/ID and EX; it outranks a load-use stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_now        <= '0;
            if_id_insn    <= NOP_INSN;
            if_id_pc      <= '0;
            id_ex_ctrl    <= '0;
            id_ex_pc      <= '0;
            id_ex_a       <= '0;
            id_ex_b       <= '0;
            ex_mem_reg_we <= 1'b0;
            ex_mem_re     <= 1'b0;
            ex_mem_we     <= 1'b0;
            ex_mem_rd     <= '0;
            ex_mem_y      <= '0;
            ex_mem_store  <= '0;
            mem_wb_we     <= 1'b0;
            mem_wb_rd     <= '0;
            mem_wb_data   <= '0;
        end else begin
            if (branch_taken) begin
                pc_now     <= ex_target;
                if_id_insn <= NOP_INSN;
                if_id_pc   <= '0;
                id_ex_ctrl <= '0;
            end else if (load_use) begin
                id_ex_ctrl <= '0;
            end else begin
                pc_now     <= pc_now + 32'd4;
                if_id_insn <= imem_data;
                if_id_pc   <= pc_now;
                id_ex_ctrl <= id_ctrl;
                id_ex_pc   <= if_id_pc;
                id_ex_a    <= id_a;
                id_ex_b    <= id_b;
            end
            ex_mem_reg_we <= id_ex_ctrl.reg_we;
            ex_mem_re     <= id_ex_ctrl.mem_re;
            ex_mem_we     <= id_ex_ctrl.mem_we;
            ex_mem_rd     <= id_ex_ctrl.rd;
            ex_mem_y      <= ex_y;
            ex_mem_store  <= ex_b;
            mem_wb_we     <= ex_mem_reg_we;
            mem_wb_rd     <= ex_mem_rd;
            mem_wb_data   <= mem_result;
        end
    end
endmodule

// File: rtl/riscv_rom.sv
// riscv_rom -- instruction ROM, read combinationally.
// Ports: word_addr (PC[31:2]), data (instruction word).
// rom_mem is loaded from a memory-file image by the environment.
module riscv_rom #(
    parameter int unsigned ROM_WORDS = 256
) (
    input  logic [29:0] word_addr,
    output logic [31:0] data
);
    localparam int unsigned AW = (ROM_WORDS > 1) ? $clog2(ROM_WORDS) : 1;

    logic [31:0]   rom_mem [0:ROM_WORDS-1];
    logic [AW-1:0] idx;

    assign idx  = AW'(word_addr % 30'(ROM_WORDS));
    assign data = rom_mem[idx];
endmodule

// File: rtl/risc_v_soc.sv
// risc_v_soc -- SoC top: instruction ROM (rom_1) feeding the core (top_1).
// Ports: clk (system clock), reset (asynchronous, active low).
module risc_v_soc #(
    parameter int unsigned ROM_WORDS  = 256,
    parameter int unsigned DMEM_WORDS = 256
) (
    input  logic clk,
    input  logic reset
);
    logic [29:0] imem_word_addr;
    logic [31:0] imem_data;

    riscv_rom #(.ROM_WORDS(ROM_WORDS)) rom_1 (
        .word_addr (imem_word_addr),
        .data      (imem_data)
    );

    riscv_core #(.DMEM_WORDS(DMEM_WORDS)) top_1 (
        .clk            (clk),
        .reset          (reset),
        .imem_word_addr (imem_word_addr),
        .imem_data      (imem_data)
    );
endmodule

// File: tb/tb_risc_v_soc.sv
// tb_risc_v_soc -- directed program with a write-back scoreboard.
module tb_risc_v_soc;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    risc_v_soc #(.ROM_WORDS(256), .DMEM_WORDS(256)) dut (
        .clk   (clk),
        .reset (reset)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    wb_t         sb [$];
    wb_t         exp_tab [18];
    logic [31:0] prog [25];
    int          errors = 0;
    int          checks = 0;
    int          stall_cnt = 0;
    int          br_cnt = 0;
    logic [31:0] prev_pc = '0;
    logic        prev_valid = 1'b0;
    logic        prev_br = 1'b0;

    localparam logic [6:0] OPI = 7'b0010011;
    localparam logic [6:0] F7A = 7'b0100000;

    function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] s_t(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] b_t(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h, required %h", tag, got, exp);
        end
    endtask

    task automatic push_all();
        for (int i = 0; i < 18; i++)
            sb.push_back(exp_tab[i]);
        br_cnt    = 0;
        stall_cnt = 0;
    endtask

    task automatic run_full(input string tag);
        for (int c = 0; c < 120 && sb.size() != 0; c++)
            @(negedge clk);
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL %s_drain: pending writes %0d, required 0", tag, sb.size());
        end
        repeat (4) @(negedge clk);
        check({tag, "_branch_cycles"}, 32'(br_cnt), 32'd1);
        check({tag, "_stall_cycles"}, 32'(stall_cnt), 32'd1);
        check({tag, "_x0"}, dut.top_1.regs[0], 32'd0);
        check({tag, "_x7_untouched"}, dut.top_1.regs[7], 32'd0);
        check({tag, "_x18_lui_nop"}, dut.top_1.regs[18], 32'd0);
    endtask

    // Write-back monitor: every WB write must match the scoreboard head.
    always @(negedge clk) begin
        if (!reset) begin
            prev_valid = 1'b0;
        end else begin
            if (dut.top_1.wb_re) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $error("FAIL wb_unexpected: got x%0d=%h, required no write",
                           dut.top_1.wb_rd, dut.top_1.wb_data);
                end else begin
                    wb_t e;
                    e = sb.pop_front();
                    assert (dut.top_1.wb_rd === e.rd && dut.top_1.wb_data === e.data) else begin
                        errors++;
                        $error("FAIL wb_write: got x%0d=%h, required x%0d=%h",
                               dut.top_1.wb_rd, dut.top_1.wb_data, e.rd, e.data);
                    end
                end
            end
            if (dut.top_1.branch_taken)
                br_cnt++;
            if (prev_valid && !prev_br && dut.top_1.pc_now == prev_pc)
                stall_cnt++;
            prev_pc    = dut.top_1.pc_now;
            prev_br    = dut.top_1.branch_taken;
            prev_valid = 1'b1;
        end
    end

    initial begin
        prog[0]  = i_t(12'd1, 5'd0, 3'b000, 5'd1, OPI);          // addi x1,x0,1
        prog[1]  = i_t(12'd2, 5'd0, 3'b000, 5'd2, OPI);          // addi x2,x0,2
        prog[2]  = r_t(7'd0, 5'd2, 5'd1, 3'b000, 5'd3);          // add x3,x1,x2
        prog[3]  = r_t(F7A, 5'd1, 5'd2, 3'b000, 5'd4);           // sub x4,x2,x1
        prog[4]  = r_t(7'd0, 5'd1, 5'd3, 3'b110, 5'd5);          // or x5,x3,x1
        prog[5]  = r_t(7'd0, 5'd2, 5'd3, 3'b111, 5'd6);          // and x6,x3,x2
        prog[6]  = s_t(12'd0, 5'd3, 5'd0);                       // sw x3,0(x0)
        prog[7]  = i_t(12'd0, 5'd0, 3'b010, 5'd8, 7'b0000011);   // lw x8,0(x0)
        prog[8]  = r_t(7'd0, 5'd8, 5'd0, 3'b010, 5'd29);         // slt x29,x0,x8
        prog[9]  = b_t(13'd8, 5'd0, 5'd1, 3'b001);               // bne x1,x0,+8
        prog[10] = i_t(12'd7, 5'd0, 3'b000, 5'd7, OPI);          // addi x7 (flushed)
        prog[11] = i_t(12'd30, 5'd0, 3'b000, 5'd30, OPI);        // addi x30,x0,30
        prog[12] = i_t(12'd5, 5'd0, 3'b000, 5'd0, OPI);          // addi x0,x0,5
        prog[13] = r_t(7'd0, 5'd1, 5'd0, 3'b000, 5'd9);          // add x9,x0,x1
        prog[14] = i_t(12'hFFF, 5'd1, 3'b100, 5'd10, OPI);       // xori x10,x1,-1
        prog[15] = r_t(F7A, 5'd1, 5'd10, 3'b101, 5'd11);         // sra x11,x10,x1
        prog[16] = r_t(7'd0, 5'd1, 5'd10, 3'b101, 5'd12);        // srl x12,x10,x1
        prog[17] = r_t(7'd0, 5'd10, 5'd1, 3'b011, 5'd13);        // sltu x13,x1,x10
        prog[18] = r_t(7'd0, 5'd2, 5'd2, 3'b001, 5'd14);         // sll x14,x2,x2
        prog[19] = i_t(12'd0, 5'd10, 3'b010, 5'd15, OPI);        // slti x15,x10,0
        prog[20] = b_t(13'd8, 5'd2, 5'd1, 3'b000);               // beq x1,x2 (not taken)
        prog[21] = i_t(12'h00F, 5'd10, 3'b111, 5'd16, OPI);      // andi x16,x10,15
        prog[22] = i_t(12'h055, 5'd0, 3'b110, 5'd17, OPI);       // ori x17,x0,0x55
        prog[23] = {20'h12345, 5'd18, 7'b0110111};               // lui: executes as NOP
        prog[24] = 32'h0000_0000;

        exp_tab[0]  = '{rd: 5'd1,  data: 32'd1};
        exp_tab[1]  = '{rd: 5'd2,  data: 32'd2};
        exp_tab[2]  = '{rd: 5'd3,  data: 32'd3};
        exp_tab[3]  = '{rd: 5'd4,  data: 32'd1};
        exp_tab[4]  = '{rd: 5'd5,  data: 32'd3};
        exp_tab[5]  = '{rd: 5'd6,  data: 32'd2};
        exp_tab[6]  = '{rd: 5'd8,  data: 32'd3};
        exp_tab[7]  = '{rd: 5'd29, data: 32'd1};
        exp_tab[8]  = '{rd: 5'd30, data: 32'd30};
        exp_tab[9]  = '{rd: 5'd9,  data: 32'd1};
        exp_tab[10] = '{rd: 5'd10, data: 32'hFFFF_FFFE};
        exp_tab[11] = '{rd: 5'd11, data: 32'hFFFF_FFFF};
        exp_tab[12] = '{rd: 5'd12, data: 32'h7FFF_FFFF};
        exp_tab[13] = '{rd: 5'd13, data: 32'd1};
        exp_tab[14] = '{rd: 5'd14, data: 32'd8};
        exp_tab[15] = '{rd: 5'd15, data: 32'd1};
        exp_tab[16] = '{rd: 5'd16, data: 32'h0000_000E};
        exp_tab[17] = '{rd: 5'd17, data: 32'h0000_0055};

        for (int i = 0; i < 256; i++)
            dut.rom_1.rom_mem[i] = 32'h0;
        for (int i = 0; i < 25; i++)
            dut.rom_1.rom_mem[i] = prog[i];

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_pc", dut.top_1.pc_now, 32'd0);
        check("rst_wb_re", 32'(dut.top_1.wb_re), 32'd0);
        check("rst_wb_rd", 32'(dut.top_1.wb_rd), 32'd0);
        check("rst_wb_data", dut.top_1.wb_data, 32'd0);
        check("rst_branch", 32'(dut.top_1.branch_taken), 32'd0);

        // First full run
        @(negedge clk);
        push_all();
        #2 reset = 1'b1;
        run_full("run1");

        // Restart, then assert reset mid-program between clock edges
        reset = 1'b0;
        @(negedge clk);
        push_all();
        #2 reset = 1'b1;
        repeat (7) @(negedge clk);
        check("pre_mid_pc_nonzero", 32'(dut.top_1.pc_now != 32'd0), 32'd1);
        #3 reset = 1'b0;
        #1;
        check("mid_rst_pc", dut.top_1.pc_now, 32'd0);
        check("mid_rst_wb_re", 32'(dut.top_1.wb_re), 32'd0);
        check("mid_rst_wb_data", dut.top_1.wb_data, 32'd0);
        check("mid_rst_branch", 32'(dut.top_1.branch_taken), 32'd0);
        check("mid_rst_x1", dut.top_1.regs[1], 32'd0);

        // Re-execution after release must be identical
        sb.delete();
        @(negedge clk);
        push_all();
        #2 reset = 1'b1;
        run_full("run2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
